i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'b1100111, the 7-bit device address it acknowledges.
REQ-002 The block SHALL have parameter REG_AW, default 4, the register-pointer width; the register file depth is 2**REG_AW bytes.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth on scl_i and sda_i (minimum 2).
REQ-004 The block SHALL have port CLK, input, 1 bit, the system clock; reset is synchronous, active-high, on signal reset, clock CLK.
REQ-005 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port scl_i, input, 1 bit, the raw SCL pad level.
REQ-007 The block SHALL have port sda_i, input, 1 bit, the raw SDA pad level.
REQ-008 The block SHALL have port sda_oe, output, 1 bit; 1 drives SDA low, 0 releases it (open-drain, never driven high).
REQ-009 The block SHALL have port wr_valid, output, 1 bit, a one-CLK pulse per register byte written by the master.
REQ-010 The block SHALL have port wr_addr, output, REG_AW bits, the register index of the current wr_valid.
REQ-011 The block SHALL have port wr_data, output, 8 bits, the byte written with the current wr_valid.
REQ-012 The block SHALL have port busy, output, 1 bit, high from an address-matched ACK until STOP or a repeated START.

Function
REQ-013 The block SHALL be fully synchronous to CLK, with no logic clocked by SCL or SDA; scl_i and sda_i pass through SYNC_STAGES flops and then edge detection.
REQ-014 START SHALL be a synchronised SDA fall while SCL is high, and STOP a synchronised SDA rise while SCL is high; both SHALL be recognised in every state.
REQ-015 START/STOP SHALL take priority over SCL-edge bit processing in the same cycle.
REQ-016 The block SHALL sample SDA on the synchronised SCL rise and SHALL change sda_oe only on the CLK cycle after the synchronised SCL fall.
REQ-017 The states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-018 State IDLE SHALL go to ADDR on START.
REQ-019 State ADDR SHALL shift 8 bits MSB first (7 address bits, then R/W).
REQ-020 If the address matches DEV_ADDR, the block SHALL enter ADDR_ACK and drive sda_oe=1 for the ninth SCL period; then go to PTR if W=0, or RDATA if R=1.
REQ-021 If the address does not match, the block SHALL enter IGNORE with sda_oe=0 until the next START or STOP.
REQ-022 The first byte after a write address SHALL be loaded into the register pointer (low REG_AW bits) and ACKed.
REQ-023 Each later byte SHALL be written to reg[ptr], pulse wr_valid with wr_addr=ptr and wr_data=byte on the cycle of the eighth bit's SCL rise, be ACKed, and then ptr SHALL increment.
REQ-024 In RDATA the block SHALL shift out reg[ptr] MSB first (sda_oe = ~bit), release SDA for the ACK slot, and increment ptr.
REQ-025 In RDATA_ACK, a master ACK (0) SHALL continue with the next byte; a NACK (1) SHALL go to IGNORE.
REQ-026 The pointer SHALL wrap from 2**REG_AW-1 to 0, and SHALL persist across transactions, so a repeated START with R=1 reads from the last pointer.
REQ-027 A STOP SHALL return the block to IDLE and release SDA; a START mid-byte SHALL abort the partial byte with no write, and go to ADDR.

Reset
REQ-028 On reset, sda_oe, wr_valid and busy SHALL be 0, wr_addr and wr_data SHALL be 0, ptr SHALL be 0, all registers SHALL be 0, the state SHALL be IDLE, and the synchronisers SHALL be set to 1.
REQ-029 Reset asserted mid-transfer SHALL release SDA on the same CLK edge; the block SHALL ignore bus activity until the next START.

Configuration
REQ-030 With I2C_SLV_GEN_CALL_EN defined, address 7'h00 with W SHALL also be ACKed and handled as a write with pointer load; address 7'h00 with R SHALL go to IGNORE.
REQ-031 Without I2C_SLV_GEN_CALL_EN, address 7'h00 SHALL NOT be ACKed, and the block SHALL go to IGNORE.

Verification (CLK = 16x SCL)
REQ-032 The bench SHALL cover: write 0x67+W, ptr 0x03, data 0xA5 and 0x5A -> ACK on all bytes; wr_valid pulses (3,0xA5) then (4,0x5A); then STOP -> busy=0.
REQ-033 The bench SHALL cover: repeated START 0x67+R after ptr 0x03 and two-byte read, master ACK then NACK -> SDA carries 0xA5, 0x5A; block in IGNORE; sda_oe=0.
REQ-034 The bench SHALL cover: address 0x55+W -> no ACK, no wr_valid, and sda_oe stays 0 for the whole transaction.
REQ-035 The bench SHALL cover: ptr 0x0F, write 0x11 and 0x22 -> wr_addr 15 then 0 (wrap).
REQ-036 The bench SHALL cover: reset pulsed during the ADDR_ACK low phase -> sda_oe=0 the next cycle, registers cleared, and the next valid transaction succeeds.
REQ-037 The bench SHALL cover: address 0x00+W, with and without I2C_SLV_GEN_CALL_EN -> ACK vs no ACK respectively.

Source files
------------

// File: rtl/i2c_slave_regfile_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2c_slave_regfile_if
// Pad-level I2C bus bundle shared by the register-file slave and whatever
// drives the bus (a pad ring, or a bus model).
//   scl_i  : raw SCL pad level (seen by the slave)
//   sda_i  : raw SDA pad level (seen by the slave)
//   sda_oe : 1 pulls SDA low, 0 releases it (open-drain, never driven high)
// Modports:
//   slave  : the register-file slave
//   master : the bus side that produces the pad levels
// -----------------------------------------------------------------------------
interface i2c_slave_regfile_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2c_slave_regfile
// I2C slave exposing a byte-wide register file of 2**REG_AW entries. The first
// byte after a write address loads the register pointer; later bytes are
// written at the pointer, which then increments (wrapping). Reads stream bytes
// from the pointer. Everything runs on CLK: SCL/SDA are synchronised and
// edge-detected, never used as clocks.
//
// Parameters:
//   DEV_ADDR    : 7-bit device address acknowledged
//   REG_AW      : register pointer width (<= 8); depth is 2**REG_AW bytes
//   SYNC_STAGES : synchroniser depth on scl_i/sda_i (minimum 2)
// Ports:
//   CLK      : system clock
//   reset    : synchronous, active-high reset
//   bus      : i2c_slave_regfile_if.slave (scl_i, sda_i in; sda_oe out)
//   wr_valid : one-CLK pulse per register byte written by the master
//   wr_addr  : register index of the current wr_valid
//   wr_data  : byte written with the current wr_valid
//   busy     : high from an address-matched ACK until STOP or repeated START
// Build option:
//   I2C_SLV_GEN_CALL_EN : also ACK the general-call address 7'h00 with W and
//                         treat it as a write (pointer load, data writes);
//                         7'h00 with R is ignored. Undefined: 7'h00 is ignored.
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR    = 7'b1100111,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  i2c_slave_regfile_if.slave    bus,
  output logic                  wr_valid,
  output logic [REG_AW-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  localparam int DEPTH = 2 ** REG_AW;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection. Reset to 1 (idle bus level) so leaving
  // reset never looks like a START.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high on both samples so an SDA change racing an SCL edge is
  // never mistaken for a bus condition.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [7:0]        regs [DEPTH];
  logic [REG_AW-1:0] ptr_q;
  logic [6:0]        shift_q;   // first seven received bits of the byte
  logic [6:0]        tx_q;      // remaining bits of the byte being read out
  logic [2:0]        bit_cnt;
  logic              ack_on;    // set once the ACK slot has been opened
  logic              rw_q;
  logic              sda_oe_q;

  logic [7:0] byte_in;
  logic       last_bit;
  logic       addr_hit, gc_hit, addr_ack;

  // The eighth bit is taken straight from the synchroniser on its SCL rise.
  assign byte_in  = {shift_q, sda_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign addr_hit = (byte_in[7:1] == DEV_ADDR);

`ifdef I2C_SLV_GEN_CALL_EN
  assign gc_hit = (byte_in[7:1] == 7'h00) && !byte_in[0];
`else
  assign gc_hit = 1'b0;
`endif

  assign addr_ack   = addr_hit | gc_hit;
  assign bus.sda_oe = sda_oe_q;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ACK states span two SCL falls: the first opens the slot, the second
  // closes it and moves on.
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch forms.
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_IDLE;
        ST_ADDR:      if (scl_rise && last_bit) state_d = addr_ack ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (scl_fall && ack_on)   state_d = rw_q ? ST_RDATA : ST_PTR;
        ST_PTR:       if (scl_rise && last_bit) state_d = ST_PTR_ACK;
        ST_PTR_ACK:   if (scl_fall && ack_on)   state_d = ST_WDATA;
        ST_WDATA:     if (scl_rise && last_bit) state_d = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall && ack_on)   state_d = ST_WDATA;
        ST_RDATA:     if (scl_rise && last_bit) state_d = ST_RDATA_ACK;
        ST_RDATA_ACK: begin
          if (scl_rise && ack_on && sda_s) state_d = ST_IGNORE;  // master NACK
          else if (scl_fall && ack_on)     state_d = ST_RDATA;
        end
        ST_IGNORE:    state_d = ST_IGNORE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: shifting, pointer, register writes and SDA drive. sda_oe is only
  // updated on an SCL-fall cycle, so it changes on the CLK after that fall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      sda_oe_q <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      ptr_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      bit_cnt  <= '0;
      ack_on   <= 1'b0;
      rw_q     <= 1'b0;
      // NOTE: the register file must read back as zero after reset, so it is
      // built from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det || stop_det) begin
        // Any partial byte is dropped; nothing is written.
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        ack_on   <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift_q <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (state_q == ST_ADDR) begin
                  rw_q <= byte_in[0];
                  busy <= addr_ack;
                end else if (state_q == ST_PTR) begin
                  ptr_q <= byte_in[REG_AW-1:0];
                end else begin
                  regs[ptr_q] <= byte_in;
                  wr_valid    <= 1'b1;
                  wr_addr     <= ptr_q;
                  wr_data     <= byte_in;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe_q <= 1'b1;
                ack_on   <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                if (state_q == ST_WDATA_ACK) ptr_q <= ptr_q + 1'b1;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  tx_q     <= regs[ptr_q][6:0];
                  sda_oe_q <= ~regs[ptr_q][7];
                end else begin
                  sda_oe_q <= 1'b0;
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
            if (scl_fall) begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= {tx_q[5:0], 1'b0};
            end
          end

          ST_RDATA_ACK: begin
            if (scl_fall && !ack_on) begin
              sda_oe_q <= 1'b0;          // master owns the ACK slot
              ack_on   <= 1'b1;
              ptr_q    <= ptr_q + 1'b1;
            end else if (scl_fall) begin
              ack_on   <= 1'b0;
              bit_cnt  <= '0;
              tx_q     <= regs[ptr_q][6:0];
              sda_oe_q <= ~regs[ptr_q][7];
            end else if (scl_rise && ack_on && sda_s) begin
              ack_on <= 1'b0;
            end
          end

          default: begin                 // IDLE, IGNORE
            sda_oe_q <= 1'b0;
            bit_cnt  <= '0;
            ack_on   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_i2c_slave_regfile
// Drives an I2C master bus model (SCL period = 16 CLK) into i2c_slave_regfile
// and compares ACKs, read data, write strobes and status against a byte-array
// model of the register file and pointer.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regfile;

  localparam logic [6:0] DEV   = 7'b1100111;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam int         Q     = 40;   // quarter SCL period, 4 CLK
  localparam logic [7:0] AW_W  = {DEV, 1'b0};
  localparam logic [7:0] AW_R  = {DEV, 1'b1};
`ifdef I2C_SLV_GEN_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  i2c_slave_regfile_if bus ();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;   // wired-AND open-drain line

  i2c_slave_regfile #(
    .DEV_ADDR    (DEV),
    .REG_AW      (AW),
    .SYNC_STAGES (2)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .bus      (bus),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [7:0] mregs [DEPTH];
  int         mptr;

  // Observed write strobes and count of CLKs with SDA driven
  logic [11:0] wr_q [$];
  int          oe_cnt = 0;

  always @(negedge CLK) begin
    if (wr_valid === 1'b1) wr_q.push_back({wr_addr, wr_data});
    if (bus.sda_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus model ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bit(input bit b);
    sda_m = b;    #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output bit acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    acked = (bus.sda_i === 1'b0);
    #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic rd_byte(input bit mack, output logic [7:0] d);
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      v[i] = bus.sda_i;
      #Q;
      scl_m = 1'b0; #Q;
    end
    send_bit(!mack);
    sda_m = 1'b1;
    d = v;
  endtask

  // ---------------- model helpers ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic check_wr(input string tag, input int a, input logic [7:0] d);
    logic [11:0] e;
    check({tag, "_present"}, (wr_q.size() > 0), 1);
    if (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      check({tag, "_addr"}, e[11:8], a);
      check({tag, "_data"}, e[7:0], d);
    end
  endtask

  // Master wrote data byte d: expect a strobe at the model pointer, then advance.
  task automatic model_write(input string tag, input logic [7:0] d);
    check_wr(tag, mptr, d);
    mregs[mptr] = d;
    mptr = (mptr + 1) % DEPTH;
  endtask

  task automatic model_read(input string tag, input logic [7:0] got);
    check(tag, got, mregs[mptr]);
    mptr = (mptr + 1) % DEPTH;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit         ack;
    logic [7:0] rd;
    logic [7:0] d;
    int         base, p, n, q, m;

    model_reset();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("rst_sda_oe",   bus.sda_oe, 0);
    check("rst_wr_valid", wr_valid,   0);
    check("rst_busy",     busy,       0);
    check("rst_wr_addr",  wr_addr,    0);
    check("rst_wr_data",  wr_data,    0);
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    // Write 0x67+W, ptr 3, A5, 5A
    i2c_start();
    wr_byte(AW_W,  ack); check("w1_addr_ack", ack, 1);
    wr_byte(8'h03, ack); check("w1_ptr_ack",  ack, 1); mptr = 3;
    wr_byte(8'hA5, ack); check("w1_d0_ack",   ack, 1); model_write("w1_d0", 8'hA5);
    wr_byte(8'h5A, ack); check("w1_d1_ack",   ack, 1); model_write("w1_d1", 8'h5A);
    check("w1_busy", busy, 1);
    i2c_stop();
    repeat (4) @(negedge CLK);
    check("w1_busy_after_stop", busy, 0);

    // Pointer 3, repeated START read two bytes, ACK then NACK
    i2c_start();
    wr_byte(AW_W,  ack); check("r1_addr_ack", ack, 1);
    wr_byte(8'h03, ack); check("r1_ptr_ack",  ack, 1); mptr = 3;
    i2c_start();
    wr_byte(AW_R,  ack); check("r1_raddr_ack", ack, 1);
    rd_byte(1'b1, rd); model_read("r1_b0", rd);
    rd_byte(1'b0, rd); model_read("r1_b1", rd);
    repeat (4) @(negedge CLK);
    check("r1_oe_after_nack", bus.sda_oe, 0);
    base = oe_cnt;
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    check("r1_ignore_quiet", oe_cnt - base, 0);
    check("r1_busy_ignore", busy, 1);
    i2c_stop();
    check("r1_no_wr", wr_q.size(), 0);

    // Foreign address 0x55+W
    base = oe_cnt;
    i2c_start();
    wr_byte({7'h55, 1'b0}, ack); check("na_addr_ack", ack, 0);
    wr_byte(8'h12, ack);         check("na_b0_ack",   ack, 0);
    wr_byte(8'h34, ack);         check("na_b1_ack",   ack, 0);
    i2c_stop();
    check("na_oe_quiet", oe_cnt - base, 0);
    check("na_no_wr",    wr_q.size(), 0);
    check("na_busy",     busy, 0);

    // Pointer wrap 15 -> 0
    i2c_start();
    wr_byte(AW_W,  ack); check("wrap_addr_ack", ack, 1);
    wr_byte(8'h0F, ack); check("wrap_ptr_ack",  ack, 1); mptr = 15;
    wr_byte(8'h11, ack); check("wrap_d0_ack",   ack, 1); model_write("wrap_d0", 8'h11);
    wr_byte(8'h22, ack); check("wrap_d1_ack",   ack, 1); model_write("wrap_d1", 8'h22);
    i2c_stop();

    // General-call address
    i2c_start();
    wr_byte(8'h00, ack); check("gc_addr_ack", ack, GC_EN);
    i2c_stop();
    check("gc_no_wr", wr_q.size(), 0);

    // Reset during the ADDR_ACK low phase
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(AW_W[i]);
    check("rst_mid_ack_driven", bus.sda_oe, 1);
    reset = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_oe_released", bus.sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    model_reset();
    @(negedge CLK);
    i2c_stop();
    i2c_start();
    wr_byte(AW_W,  ack); check("rst_rd_addr_ack", ack, 1);
    wr_byte(8'h03, ack); check("rst_rd_ptr_ack",  ack, 1); mptr = 3;
    i2c_start();
    wr_byte(AW_R,  ack); check("rst_rd_raddr_ack", ack, 1);
    rd_byte(1'b0, rd); model_read("rst_rd_cleared", rd);
    i2c_stop();
    i2c_start();
    wr_byte(AW_W,  ack); check("rst_wr_addr_ack", ack, 1);
    wr_byte(8'h07, ack); check("rst_wr_ptr_ack",  ack, 1); mptr = 7;
    wr_byte(8'h3C, ack); check("rst_wr_d_ack",    ack, 1); model_write("rst_wr", 8'h3C);
    i2c_start();
    wr_byte(AW_W,  ack); check("rst_rb_addr_ack", ack, 1);
    wr_byte(8'h07, ack); check("rst_rb_ptr_ack",  ack, 1); mptr = 7;
    i2c_start();
    wr_byte(AW_R,  ack); check("rst_rb_raddr_ack", ack, 1);
    rd_byte(1'b0, rd); model_read("rst_rb", rd);
    i2c_stop();

    // Randomised write bursts, read bursts, and pointer persistence
    for (int t = 0; t < 6; t++) begin
      p = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 4);
      i2c_start();
      wr_byte(AW_W, ack);       check($sformatf("rnd%0d_waddr_ack", t), ack, 1);
      wr_byte(8'(p), ack);      check($sformatf("rnd%0d_wptr_ack", t), ack, 1);
      mptr = p;
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        wr_byte(d, ack);        check($sformatf("rnd%0d_wd%0d_ack", t, j), ack, 1);
        model_write($sformatf("rnd%0d_wd%0d", t, j), d);
      end
      i2c_stop();

      q = $urandom_range(0, DEPTH - 1);
      m = $urandom_range(1, 5);
      i2c_start();
      wr_byte(AW_W, ack);       check($sformatf("rnd%0d_raddrw_ack", t), ack, 1);
      wr_byte(8'(q), ack);      check($sformatf("rnd%0d_rptr_ack", t), ack, 1);
      mptr = q;
      i2c_start();
      wr_byte(AW_R, ack);       check($sformatf("rnd%0d_raddr_ack", t), ack, 1);
      for (int j = 0; j < m; j++) begin
        rd_byte(j < m - 1, rd);
        model_read($sformatf("rnd%0d_rd%0d", t, j), rd);
      end
      i2c_stop();

      // New transaction, read only: continues from the persisted pointer
      i2c_start();
      wr_byte(AW_R, ack);       check($sformatf("rnd%0d_paddr_ack", t), ack, 1);
      rd_byte(1'b0, rd);
      model_read($sformatf("rnd%0d_persist", t), rd);
      i2c_stop();
    end
    check("final_no_stray_wr", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
